frame_ingest: RTL and testbench
===============================

# frame_ingest

Parametrised multi-channel frame loader at the head of the lane-detection pipeline. Pops NUM_CH pixel FIFOs (image, mask, …), writes each pixel into its channel's frame BRAM and optionally forwards it to a downstream filter FIFO. It double-buffers frames across NUM_BANKS BRAM banks so frame N+1 loads while hough processes frame N. It signals per-frame completion to the hough controller.

## Interface
Parameters:
- NUM_CH, 2, number of input channels (0 = image, 1 = mask)
- DATA_WIDTH, 24, pixel width, all channels
- IMAGE_SIZE, 388800, pixels per frame (720×540)
- NUM_BANKS, 2, frame banks per channel BRAM; 1 = single-buffer
- FWD_MASK, 2'b01, bit c set = channel c also forwards to its downstream FIFO
- ADDR_W (derived), $clog2(IMAGE_SIZE*NUM_BANKS)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- in_empty  in  [NUM_CH]  source FIFO empty, show-ahead
- in_dout  in  [NUM_CH][DATA_WIDTH]  source FIFO head word
- in_rd_en  out  [NUM_CH]  pop
- fwd_full  in  [NUM_CH]  downstream FIFO full; ignored where FWD_MASK bit clear
- fwd_wr_en  out  [NUM_CH]  downstream push
- fwd_din  out  [NUM_CH][DATA_WIDTH]  downstream data
- bram_wr_en  out  [NUM_CH]  BRAM write enable
- bram_wr_addr  out  [NUM_CH][ADDR_W]  bank*IMAGE_SIZE + pixel index
- bram_wr_data  out  [NUM_CH][DATA_WIDTH]  BRAM data
- frame_ready  out  1  one-cycle pulse: a bank holds a complete frame on all channels
- frame_bank  out  $clog2(NUM_BANKS)∨1  bank just completed; held until next frame_ready
- frame_release  in  1  consumer finished with release_bank (pulse)
- release_bank  in  $clog2(NUM_BANKS)∨1  bank being released
- frames_pending  out  $clog2(NUM_BANKS+1)  banks currently READY
- release_err  out  1  sticky: release of a bank not in READY

## Operation
- Bank state per bank: FREE → FILLING → READY → FREE. Write pointer wr_bank starts at 0.
- Channel FSM (per channel): WAIT → LOAD → DONE → WAIT.
  - WAIT → LOAD when bank wr_bank is FREE or FILLING; that bank goes FILLING.
  - LOAD: pop when !in_empty[c] && (!FWD_MASK[c] || !fwd_full[c]). Pop is combinational in the same cycle.
  - Each pop asserts bram_wr_en, bram_wr_addr = wr_bank*IMAGE_SIZE + cnt[c], bram_wr_data = in_dout[c], and fwd_wr_en/fwd_din if forwarded. cnt[c] then increments.
  - Pop with cnt[c] = IMAGE_SIZE-1: cnt[c] ← 0, channel → DONE. A DONE channel never pops.
- All channels DONE:
  - bank wr_bank → READY; frame_ready pulses; frame_bank ← wr_bank.
  - wr_bank ← (wr_bank+1) mod NUM_BANKS; all channels → WAIT.
- Channels finish independently; a fast channel waits in DONE for the slowest one.
- frame_release on a READY bank → FREE. Release on a FREE/FILLING bank: ignored, release_err ← 1 (cleared only by reset).
- Release and WAIT-check of the same bank in the same cycle: the release wins, and LOAD begins on the following cycle.
- No bank FREE (all READY): all channels stall in WAIT, no pops; sources back up via their FIFOs.
- NUM_BANKS = 1: behaves as a plain loader. The next frame waits for frame_release.

## Timing
- Reset (reset = 0): cnt = 0; wr_bank = 0; all banks FREE; channels WAIT. All outputs 0, including frame_bank, frames_pending and release_err.
- Reset mid-frame discards the partial frame. BRAM contents are don't-care.
- Pop, BRAM write and forward push all occur in the same cycle t. Zero latency.
- Throughput: 1 pixel/channel/cycle sustained.
- Last pop of the last channel at cycle t:
  - frame_ready = 1 at t+1 only; frames_pending increments at t+1.
  - channels are in WAIT at t+1; earliest next-bank pop is t+2.
- First pop after reset: no earlier than the second rising edge after reset deasserts (WAIT → LOAD takes one cycle).
- frame_release at t: bank FREE and frames_pending decremented at t+1.

## Structure
- Shared package entries in globals.sv:
  - IMAGE_SIZE, NUM_BANKS
  - enum bank_state_t {FREE, FILLING, READY}
  - enum ingest_ch_state_t {WAIT, LOAD, DONE}
- Sub-module ingest_channel: per-channel FSM, pixel counter, pop/write/forward logic. Instantiated NUM_CH times by generate.
- frame_ingest holds bank states, wr_bank, the completion AND-reduce, and release handling.

## Test plan
Benches use IMAGE_SIZE = 16, NUM_CH = 2, NUM_BANKS = 2, FWD_MASK = 01.
- Both FIFOs preloaded with 16 words, never empty → 16 consecutive pops per channel, addrs 0..15; fwd_wr_en[0] ×16, fwd_wr_en[1] never; frame_ready at cycle 17, frame_bank = 0.
- Second frame streamed without release → addrs 16..31, frame_ready with frame_bank = 1, frames_pending = 2; third frame stalls with zero pops until frame_release(bank 0), then writes addrs 0..15.
- Ch0 fwd_full held high for 5 cycles mid-frame → ch0 pops pause exactly 5 cycles, no fwd write while full; ch1 completes early and sits in DONE; single frame_ready after ch0's last pop.
- frame_release(bank 1) while bank 1 FILLING → release_err = 1 and stays 1; bank 1 still completes normally.
- reset low at pixel 7 → all outputs 0 next edge; after release, the first write goes to addr 0 of bank 0.
- NUM_BANKS = 1 → second frame pops only after frame_release(0); addrs 0..15 reused.

Source files
------------

// File: rtl/frame_ingest_pkg.sv
// Shared types and default frame geometry for the frame ingest block.
package frame_ingest_pkg;

  localparam int IMAGE_SIZE = 388800;
  localparam int NUM_BANKS  = 2;

  typedef enum logic [1:0] {FREE, FILLING, READY} bank_state_t;
  typedef enum logic [1:0] {WAIT, LOAD, DONE} ingest_ch_state_t;

  // Width of a field holding values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_ingest_channel.sv
// One input channel: WAIT/LOAD/DONE sequencing, pixel counter, and the
// zero-latency pop that writes BRAM and optionally forwards downstream.
module ingest_channel #(
  parameter int DATA_WIDTH = 24,
  parameter int IMAGE_SIZE = frame_ingest_pkg::IMAGE_SIZE,
  parameter int ADDR_W     = 20,
  parameter bit FWD        = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  complete,
  input  logic [ADDR_W-1:0]     base,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  in_rd_en,
  input  logic                  fwd_full,
  output logic                  fwd_wr_en,
  output logic [DATA_WIDTH-1:0] fwd_din,
  output logic                  bram_wr_en,
  output logic [ADDR_W-1:0]     bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic                  waiting,
  output logic                  finished
);
  import frame_ingest_pkg::*;

  localparam int CNT_W = clog2_min1(IMAGE_SIZE);

  ingest_ch_state_t state;
  logic [CNT_W-1:0] cnt;
  logic             pop;
  logic             last;

  assign pop  = (state == LOAD) && !in_empty && !(FWD && fwd_full);
  assign last = (cnt == CNT_W'(IMAGE_SIZE - 1));

  assign waiting  = (state == WAIT);
  // Counts as finished in the very cycle of the last pop so completion is seen without a bubble.
  assign finished = (state == DONE) || (pop && last);

  assign in_rd_en     = pop;
  assign bram_wr_en   = pop;
  assign fwd_wr_en    = pop && FWD;
  assign bram_wr_addr = pop ? (base + ADDR_W'(cnt)) : '0;
  assign bram_wr_data = pop ? in_dout : '0;
  assign fwd_din      = (pop && FWD) ? in_dout : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= WAIT;
      cnt   <= '0;
    end else if (complete) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      case (state)
        WAIT: if (start) state <= LOAD;
        LOAD: begin
          if (pop) begin
            if (last) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: rtl/frame_ingest.sv
// Multi-channel frame loader: per-channel loaders write a bank of each channel's
// frame BRAM; banks rotate FREE -> FILLING -> READY -> FREE under consumer release.
module frame_ingest #(
  parameter int                NUM_CH     = 2,
  parameter int                DATA_WIDTH = 24,
  parameter int                IMAGE_SIZE = frame_ingest_pkg::IMAGE_SIZE,
  parameter int                NUM_BANKS  = frame_ingest_pkg::NUM_BANKS,
  parameter logic [NUM_CH-1:0] FWD_MASK   = NUM_CH'(1),
  localparam int ADDR_W = frame_ingest_pkg::clog2_min1(IMAGE_SIZE * NUM_BANKS),
  localparam int BANK_W = frame_ingest_pkg::clog2_min1(NUM_BANKS),
  localparam int PEND_W = frame_ingest_pkg::clog2_min1(NUM_BANKS + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CH-1:0]                  in_empty,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  in_dout,
  output logic [NUM_CH-1:0]                  in_rd_en,
  input  logic [NUM_CH-1:0]                  fwd_full,
  output logic [NUM_CH-1:0]                  fwd_wr_en,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]  fwd_din,
  output logic [NUM_CH-1:0]                  bram_wr_en,
  output logic [NUM_CH-1:0][ADDR_W-1:0]      bram_wr_addr,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]  bram_wr_data,
  output logic                               frame_ready,
  output logic [BANK_W-1:0]                  frame_bank,
  input  logic                               frame_release,
  input  logic [BANK_W-1:0]                  release_bank,
  output logic [PEND_W-1:0]                  frames_pending,
  output logic                               release_err
);
  import frame_ingest_pkg::*;

  bank_state_t       bank_state [NUM_BANKS];
  bank_state_t       wr_state;
  bank_state_t       rel_state;
  logic              rel_in_range;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] base;
  logic [NUM_CH-1:0] waiting;
  logic [NUM_CH-1:0] finished;
  logic [PEND_W-1:0] pending;
  logic              start;
  logic              complete;
  logic              any_waiting;
  logic              rel_ok;
  logic              rel_bad;

  // Bank lookups are done by compare rather than by indexing so that a
  // non-power-of-two bank count or an out-of-range release is handled cleanly.
  always_comb begin
    wr_state     = FREE;
    rel_state    = FREE;
    rel_in_range = 1'b0;
    pending      = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_bank == BANK_W'(b)) wr_state = bank_state[b];
      if (release_bank == BANK_W'(b)) begin
        rel_state    = bank_state[b];
        rel_in_range = 1'b1;
      end
      if (bank_state[b] == READY) pending = pending + PEND_W'(1);
    end
  end

  assign base           = ADDR_W'(wr_bank) * ADDR_W'(IMAGE_SIZE);
  assign start          = (wr_state != READY);
  assign complete       = &finished;
  assign any_waiting    = |waiting;
  assign rel_ok         = frame_release && rel_in_range && (rel_state == READY);
  assign rel_bad        = frame_release && !rel_ok;
  assign frames_pending = pending;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_state[b] <= FREE;
      wr_bank     <= '0;
      frame_ready <= 1'b0;
      frame_bank  <= '0;
      release_err <= 1'b0;
    end else begin
      frame_ready <= complete;
      if (rel_bad) release_err <= 1'b1;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (wr_bank == BANK_W'(b)) begin
          if (complete) bank_state[b] <= READY;
          else if (any_waiting && start) bank_state[b] <= FILLING;
        end
        if (rel_ok && (release_bank == BANK_W'(b))) bank_state[b] <= FREE;
      end
      if (complete) begin
        frame_bank <= wr_bank;
        wr_bank    <= (wr_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : wr_bank + BANK_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ingest_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMAGE_SIZE (IMAGE_SIZE),
      .ADDR_W     (ADDR_W),
      .FWD        (FWD_MASK[c])
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .complete     (complete),
      .base         (base),
      .in_empty     (in_empty[c]),
      .in_dout      (in_dout[c]),
      .in_rd_en     (in_rd_en[c]),
      .fwd_full     (fwd_full[c]),
      .fwd_wr_en    (fwd_wr_en[c]),
      .fwd_din      (fwd_din[c]),
      .bram_wr_en   (bram_wr_en[c]),
      .bram_wr_addr (bram_wr_addr[c]),
      .bram_wr_data (bram_wr_data[c]),
      .waiting      (waiting[c]),
      .finished     (finished[c])
    );
  end

endmodule

// File: tb/tb_frame_ingest.sv
// Directed bench for frame_ingest: IMAGE_SIZE 16, two channels, channel 0 forwarded;
// a second instance with a single bank covers the plain-loader mode.
`timescale 1ns/1ps
module tb_frame_ingest;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Two-bank instance
  logic [1:0]       in_empty, in_rd_en, fwd_full, fwd_wr_en, bram_wr_en;
  logic [1:0][23:0] in_dout, fwd_din, bram_wr_data;
  logic [1:0][4:0]  bram_wr_addr;
  logic             frame_ready, frame_bank, frame_release, release_bank, release_err;
  logic [1:0]       frames_pending;
  logic [1:0][15:0] wcount;

  // Single-bank instance
  logic [1:0]       in_empty_s, in_rd_en_s, fwd_full_s, fwd_wr_en_s, bram_wr_en_s;
  logic [1:0][23:0] in_dout_s, fwd_din_s, bram_wr_data_s;
  logic [1:0][3:0]  bram_wr_addr_s;
  logic             frame_ready_s, frame_bank_s, frame_release_s, release_bank_s, release_err_s;
  logic             frames_pending_s;
  logic [1:0][15:0] wcount_s;

  // Show-ahead source FIFOs: head word is {tag, running word index}
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      in_dout[c]   = {8'(c + 1), wcount[c]};
      in_dout_s[c] = {8'(c + 16), wcount_s[c]};
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcount   <= '0;
      wcount_s <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (in_rd_en[c])   wcount[c]   <= wcount[c] + 16'd1;
        if (in_rd_en_s[c]) wcount_s[c] <= wcount_s[c] + 16'd1;
      end
    end
  end

  frame_ingest #(.NUM_CH(2), .DATA_WIDTH(24), .IMAGE_SIZE(16), .NUM_BANKS(2), .FWD_MASK(2'b01)) dut (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
    .fwd_full(fwd_full), .fwd_wr_en(fwd_wr_en), .fwd_din(fwd_din), .bram_wr_en(bram_wr_en),
    .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data), .frame_ready(frame_ready),
    .frame_bank(frame_bank), .frame_release(frame_release), .release_bank(release_bank),
    .frames_pending(frames_pending), .release_err(release_err)
  );

  frame_ingest #(.NUM_CH(2), .DATA_WIDTH(24), .IMAGE_SIZE(16), .NUM_BANKS(1), .FWD_MASK(2'b01)) dut_s (
    .clock(clock), .reset(reset), .in_empty(in_empty_s), .in_dout(in_dout_s), .in_rd_en(in_rd_en_s),
    .fwd_full(fwd_full_s), .fwd_wr_en(fwd_wr_en_s), .fwd_din(fwd_din_s), .bram_wr_en(bram_wr_en_s),
    .bram_wr_addr(bram_wr_addr_s), .bram_wr_data(bram_wr_data_s), .frame_ready(frame_ready_s),
    .frame_bank(frame_bank_s), .frame_release(frame_release_s), .release_bank(release_bank_s),
    .frames_pending(frames_pending_s), .release_err(release_err_s)
  );

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    in_empty = 2'b00;  fwd_full = 2'b00;  frame_release = 1'b0;  release_bank = 1'b0;
    in_empty_s = 2'b11; fwd_full_s = 2'b00; frame_release_s = 1'b0; release_bank_s = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (in_rd_en !== 2'b00 || bram_wr_en !== 2'b00 || fwd_wr_en !== 2'b00) begin
      bad++; $display("FAIL reset_enables got rd=%b wr=%b fwd=%b exp 00", in_rd_en, bram_wr_en, fwd_wr_en);
    end
    total++;
    if (bram_wr_addr !== '0 || bram_wr_data !== '0 || fwd_din !== '0) begin
      bad++; $display("FAIL reset_data got addr=%h data=%h fwd=%h exp 0", bram_wr_addr, bram_wr_data, fwd_din);
    end
    total++;
    if (frame_ready !== 1'b0 || frame_bank !== 1'b0 || frames_pending !== 2'd0 || release_err !== 1'b0) begin
      bad++; $display("FAIL reset_status got rdy=%b bank=%b pend=%0d err=%b exp 0", frame_ready, frame_bank, frames_pending, release_err);
    end
    @(negedge clock);
    #1;
    total++;
    if (in_rd_en !== 2'b00) begin
      bad++; $display("FAIL reset_hold got rd=%b exp 00", in_rd_en);
    end
    reset = 1'b1;
  endtask

  // Cycle 1 is the first cycle after the first post-reset edge.
  task automatic test_first_frame();
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clock);
      #1;
      if (cyc <= 16) begin
        total++;
        if (in_rd_en !== 2'b11 || bram_wr_en !== 2'b11 || frame_ready !== 1'b0) begin
          bad++; $display("FAIL first_pop cyc=%0d got rd=%b wr=%b rdy=%b exp 11/11/0", cyc, in_rd_en, bram_wr_en, frame_ready);
        end
        for (int c = 0; c < 2; c++) begin
          total++;
          if (bram_wr_addr[c] !== 5'(cyc - 1) || bram_wr_data[c] !== {8'(c + 1), 16'(cyc - 1)}) begin
            bad++; $display("FAIL first_write ch%0d cyc=%0d got addr=%0d data=%h exp addr=%0d", c, cyc, bram_wr_addr[c], bram_wr_data[c], cyc - 1);
          end
        end
        total++;
        if (fwd_wr_en !== 2'b01 || fwd_din[0] !== {8'd1, 16'(cyc - 1)}) begin
          bad++; $display("FAIL first_fwd cyc=%0d got en=%b din=%h exp 01", cyc, fwd_wr_en, fwd_din[0]);
        end
      end else begin
        total++;
        if (frame_ready !== 1'b1 || frame_bank !== 1'b0 || frames_pending !== 2'd1 || in_rd_en !== 2'b00) begin
          bad++; $display("FAIL first_ready got rdy=%b bank=%b pend=%0d rd=%b exp 1/0/1/00", frame_ready, frame_bank, frames_pending, in_rd_en);
        end
      end
    end
  endtask

  task automatic test_second_frame_stall();
    int pops;
    for (int cyc = 18; cyc <= 34; cyc++) begin
      @(negedge clock);
      #1;
      if (cyc <= 33) begin
        for (int c = 0; c < 2; c++) begin
          total++;
          if (in_rd_en[c] !== 1'b1 || bram_wr_addr[c] !== 5'(16 + cyc - 18) || bram_wr_data[c] !== {8'(c + 1), 16'(16 + cyc - 18)}) begin
            bad++; $display("FAIL second_write ch%0d cyc=%0d got rd=%b addr=%0d exp addr=%0d", c, cyc, in_rd_en[c], bram_wr_addr[c], 16 + cyc - 18);
          end
        end
        total++;
        if (frame_ready !== 1'b0) begin
          bad++; $display("FAIL second_early_ready cyc=%0d got %b exp 0", cyc, frame_ready);
        end
      end else begin
        total++;
        if (frame_ready !== 1'b1 || frame_bank !== 1'b1 || frames_pending !== 2'd2) begin
          bad++; $display("FAIL second_ready got rdy=%b bank=%b pend=%0d exp 1/1/2", frame_ready, frame_bank, frames_pending);
        end
      end
    end
    pops = 0;
    for (int cyc = 35; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (cyc == 40) begin
        frame_release = 1'b1;
        release_bank  = 1'b0;
      end
      #1;
      if (in_rd_en !== 2'b00) pops++;
      if (cyc == 35) begin
        total++;
        if (frame_ready !== 1'b0) begin
          bad++; $display("FAIL ready_pulse_width got %b exp 0", frame_ready);
        end
      end
    end
    total++;
    if (pops !== 0) begin
      bad++; $display("FAIL stall_pops got %0d exp 0", pops);
    end
    @(negedge clock);
    frame_release = 1'b0;
    #1;
    total++;
    if (frames_pending !== 2'd1 || in_rd_en !== 2'b00 || release_err !== 1'b0) begin
      bad++; $display("FAIL release_free got pend=%0d rd=%b err=%b exp 1/00/0", frames_pending, in_rd_en, release_err);
    end
    for (int cyc = 42; cyc <= 58; cyc++) begin
      @(negedge clock);
      #1;
      if (cyc <= 57) begin
        total++;
        if (in_rd_en !== 2'b11 || bram_wr_addr[0] !== 5'(cyc - 42) || bram_wr_addr[1] !== 5'(cyc - 42)
            || bram_wr_data[0] !== {8'd1, 16'(32 + cyc - 42)}) begin
          bad++; $display("FAIL third_write cyc=%0d got rd=%b addr0=%0d addr1=%0d data0=%h exp addr=%0d", cyc, in_rd_en, bram_wr_addr[0], bram_wr_addr[1], bram_wr_data[0], cyc - 42);
        end
      end else begin
        total++;
        if (frame_ready !== 1'b1 || frame_bank !== 1'b0 || frames_pending !== 2'd2) begin
          bad++; $display("FAIL third_ready got rdy=%b bank=%b pend=%0d exp 1/0/2", frame_ready, frame_bank, frames_pending);
        end
      end
    end
  endtask

  task automatic test_fwd_backpressure();
    logic [1:0] exp_rd;
    int n0;
    apply_reset();
    n0 = 0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clock);
      // Both bits raised: the unforwarded channel must ignore its full flag.
      fwd_full = (cyc >= 5 && cyc <= 9) ? 2'b11 : 2'b00;
      #1;
      exp_rd = {cyc <= 16, (cyc <= 21) && !(cyc >= 5 && cyc <= 9)};
      if (cyc <= 21) begin
        total++;
        if (in_rd_en !== exp_rd || fwd_wr_en !== {1'b0, exp_rd[0]} || frame_ready !== 1'b0) begin
          bad++; $display("FAIL bp_pop cyc=%0d got rd=%b fwd=%b rdy=%b exp rd=%b fwd=%b", cyc, in_rd_en, fwd_wr_en, frame_ready, exp_rd, {1'b0, exp_rd[0]});
        end
        if (exp_rd[0]) begin
          total++;
          if (bram_wr_addr[0] !== 5'(n0) || bram_wr_data[0] !== {8'd1, 16'(n0)}) begin
            bad++; $display("FAIL bp_addr cyc=%0d got addr=%0d data=%h exp addr=%0d", cyc, bram_wr_addr[0], bram_wr_data[0], n0);
          end
          n0++;
        end
      end else begin
        total++;
        if (frame_ready !== 1'b1 || frame_bank !== 1'b0 || in_rd_en !== 2'b00) begin
          bad++; $display("FAIL bp_ready got rdy=%b bank=%b rd=%b exp 1/0/00", frame_ready, frame_bank, in_rd_en);
        end
      end
    end
  endtask

  // Continues from the backpressure frame: bank 1 fills from cycle 23.
  task automatic test_release_err();
    for (int cyc = 23; cyc <= 39; cyc++) begin
      @(negedge clock);
      frame_release = (cyc == 25);
      release_bank  = 1'b1;
      #1;
      if (cyc == 25) begin
        total++;
        if (release_err !== 1'b0) begin
          bad++; $display("FAIL err_before got %b exp 0", release_err);
        end
      end
      if (cyc >= 26) begin
        total++;
        if (release_err !== 1'b1) begin
          bad++; $display("FAIL err_sticky cyc=%0d got %b exp 1", cyc, release_err);
        end
      end
      if (cyc <= 38) begin
        total++;
        if (in_rd_en !== 2'b11 || bram_wr_addr[0] !== 5'(16 + cyc - 23) || bram_wr_addr[1] !== 5'(16 + cyc - 23)) begin
          bad++; $display("FAIL err_fill cyc=%0d got rd=%b addr0=%0d addr1=%0d exp addr=%0d", cyc, in_rd_en, bram_wr_addr[0], bram_wr_addr[1], 16 + cyc - 23);
        end
      end else begin
        total++;
        if (frame_ready !== 1'b1 || frame_bank !== 1'b1 || frames_pending !== 2'd2) begin
          bad++; $display("FAIL err_ready got rdy=%b bank=%b pend=%0d exp 1/1/2", frame_ready, frame_bank, frames_pending);
        end
      end
    end
    frame_release = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (release_err !== 1'b0 || frames_pending !== 2'd0 || frame_bank !== 1'b0 || frame_ready !== 1'b0) begin
      bad++; $display("FAIL rst_clears got err=%b pend=%0d bank=%b rdy=%b exp 0", release_err, frames_pending, frame_bank, frame_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clock);
      #1;
      total++;
      if (in_rd_en !== 2'b11 || bram_wr_addr[0] !== 5'(cyc - 1)) begin
        bad++; $display("FAIL rst_prefill cyc=%0d got rd=%b addr=%0d exp 11/%0d", cyc, in_rd_en, bram_wr_addr[0], cyc - 1);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (in_rd_en !== 2'b00 || bram_wr_en !== 2'b00 || fwd_wr_en !== 2'b00
        || bram_wr_addr !== '0 || bram_wr_data !== '0 || fwd_din !== '0) begin
      bad++; $display("FAIL rst_mid got rd=%b wr=%b fwd=%b addr=%h exp all 0", in_rd_en, bram_wr_en, fwd_wr_en, bram_wr_addr);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    total++;
    if (bram_wr_en !== 2'b11 || bram_wr_addr !== '0 || bram_wr_data[0] !== 24'h010000 || bram_wr_data[1] !== 24'h020000) begin
      bad++; $display("FAIL rst_restart got wr=%b addr=%h data=%h exp 11/0/020000_010000", bram_wr_en, bram_wr_addr, bram_wr_data);
    end
  endtask

  task automatic test_single_bank();
    int pops;
    in_empty = 2'b11;
    apply_reset();
    in_empty_s = 2'b00;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clock);
      #1;
      if (cyc <= 16) begin
        total++;
        if (in_rd_en_s !== 2'b11 || bram_wr_addr_s[0] !== 4'(cyc - 1) || bram_wr_addr_s[1] !== 4'(cyc - 1)) begin
          bad++; $display("FAIL sb_first cyc=%0d got rd=%b addr0=%0d exp 11/%0d", cyc, in_rd_en_s, bram_wr_addr_s[0], cyc - 1);
        end
      end else begin
        total++;
        if (frame_ready_s !== 1'b1 || frame_bank_s !== 1'b0 || frames_pending_s !== 1'b1) begin
          bad++; $display("FAIL sb_ready got rdy=%b bank=%b pend=%b exp 1/0/1", frame_ready_s, frame_bank_s, frames_pending_s);
        end
      end
    end
    pops = 0;
    for (int cyc = 18; cyc <= 22; cyc++) begin
      @(negedge clock);
      if (cyc == 22) begin
        frame_release_s = 1'b1;
        release_bank_s  = 1'b0;
      end
      #1;
      if (in_rd_en_s !== 2'b00) pops++;
    end
    total++;
    if (pops !== 0) begin
      bad++; $display("FAIL sb_stall got %0d pops exp 0", pops);
    end
    @(negedge clock);
    frame_release_s = 1'b0;
    #1;
    total++;
    if (frames_pending_s !== 1'b0 || in_rd_en_s !== 2'b00 || release_err_s !== 1'b0) begin
      bad++; $display("FAIL sb_release got pend=%b rd=%b err=%b exp 0/00/0", frames_pending_s, in_rd_en_s, release_err_s);
    end
    for (int cyc = 24; cyc <= 40; cyc++) begin
      @(negedge clock);
      #1;
      if (cyc <= 39) begin
        total++;
        if (in_rd_en_s !== 2'b11 || bram_wr_addr_s[0] !== 4'(cyc - 24) || bram_wr_data_s[0] !== {8'd16, 16'(16 + cyc - 24)}) begin
          bad++; $display("FAIL sb_second cyc=%0d got rd=%b addr0=%0d data0=%h exp addr=%0d", cyc, in_rd_en_s, bram_wr_addr_s[0], bram_wr_data_s[0], cyc - 24);
        end
      end else begin
        total++;
        if (frame_ready_s !== 1'b1 || frame_bank_s !== 1'b0 || frames_pending_s !== 1'b1) begin
          bad++; $display("FAIL sb_ready2 got rdy=%b bank=%b pend=%b exp 1/0/1", frame_ready_s, frame_bank_s, frames_pending_s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame_stall();
    test_fwd_backpressure();
    test_release_err();
    test_reset_mid_frame();
    test_single_bank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
